tff_counter: RTL

Parametrised successor to the single-bit synchronous T flip-flop. It is a WIDTH-bit register built from T-type stages, selectable as one of four modes:
- independent toggle bank
- modulo up counter
- modulo down counter
- hold

It supports synchronous clear, parallel load and a terminal-count pulse. Like the single-bit cell, the visible output is registered one cycle behind the internal state. It is used as the general divider/counter primitive across the design.

---
 rtl/tff_counter.sv | 105 ++++++++++
 1 files changed

// File: rtl/tff_counter.sv
// WIDTH-bit bank of T stages: toggle bank, modulo up/down counter or hold.
// Supports synchronous clear and load. q and tc are registered one clock behind the state.
module tff_counter #(
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MODULUS = 64'(1) << WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic             sclr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  typedef enum logic [1:0] {
    ModeToggle = 2'd0,
    ModeUp     = 2'd1,
    ModeDown   = 2'd2,
    ModeHold   = 2'd3
  } mode_e;

  localparam logic [WIDTH-1:0] ModMax = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] s_q, s_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;

  logic [WIDTH-1:0] up_tog, dn_tog;
  logic             carry_up, carry_dn;

  // Stage i toggles when all lower stages are 1 (up) or all are 0 (down).
  always_comb begin
    up_tog   = '0;
    dn_tog   = '0;
    carry_up = 1'b1;
    carry_dn = 1'b1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      up_tog[i] = carry_up;
      dn_tog[i] = carry_dn;
      carry_up  = carry_up & s_q[i];
      carry_dn  = carry_dn & ~s_q[i];
    end
  end

  always_comb begin
    s_d    = s_q;
    wrap_d = 1'b0;
    if (sclr) begin
      s_d = '0;
    end else if (load) begin
      s_d = d;
    end else if (en) begin
      unique case (mode_e'(mode))
        ModeToggle: s_d = s_q ^ t;
        ModeUp: begin
          // A loaded value above the modulus also wraps straight to zero.
          if (s_q >= ModMax) begin
            s_d    = '0;
            wrap_d = 1'b1;
          end else begin
            s_d = s_q ^ up_tog;
          end
        end
        ModeDown: begin
          if (s_q == '0) begin
            s_d    = ModMax;
            wrap_d = 1'b1;
          end else begin
            s_d = s_q ^ dn_tog;
          end
        end
        ModeHold: s_d = s_q;
        default:  s_d = s_q;
      endcase
    end
  end

  always_comb begin
    q_d  = s_q;
    tc_d = wrap_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_q    <= '0;
      wrap_q <= 1'b0;
      q_q    <= '0;
      tc_q   <= 1'b0;
    end else begin
      s_q    <= s_d;
      wrap_q <= wrap_d;
      q_q    <= q_d;
      tc_q   <= tc_d;
    end
  end

  assign q  = q_q;
  assign tc = tc_q;

endmodule
